// File: rtl/spi_pwm_config.sv
// spi_pwm_config: write-only SPI (mode 0) receiver that holds the five
// configuration registers for pwm_peripheral. The SPI pins are treated as
// plain data. They are synchronised into clk and edge-detected, and are never
// used as clocks.
//
// Output pulse semantics: wr_strobe and frame_err are single-cycle,
// registered pulses with no handshake. wr_strobe is high during the first
// cycle in which the newly written register value is visible. frame_err is
// high during the matching cycle for a discarded frame. They are never high
// together.
module spi_pwm_config #(
    parameter int MAX_ADDR    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    // Use at least two synchroniser flops, even if a smaller value is passed.
    localparam int SS       = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int NUM_REGS = 5;
    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_OVF  = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    logic [SS-1:0] sclk_sync;
    logic [SS-1:0] copi_sync;
    logic [SS-1:0] ncs_sync;
    logic          sclk_hist;
    logic          ncs_hist;

    logic sclk_cur;
    logic copi_cur;
    logic ncs_cur;
    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        commit_ok;
    logic        do_commit;
    logic        do_err;

    logic [7:0] regs_q [NUM_REGS];
    logic       wr_strobe_q;
    logic       frame_err_q;

    // Synchronise the SPI pins. The ncs flops reset high and the sclk flops
    // reset low, which are the idle levels, so releasing reset creates no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_hist <= 1'b0;
            ncs_hist  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SS-2:0], sclk};
            copi_sync <= {copi_sync[SS-2:0], copi};
            ncs_sync  <= {ncs_sync[SS-2:0], ncs};
            sclk_hist <= sclk_sync[SS-1];
            ncs_hist  <= ncs_sync[SS-1];
        end
    end

    assign sclk_cur  = sclk_sync[SS-1];
    assign copi_cur  = copi_sync[SS-1];
    assign ncs_cur   = ncs_sync[SS-1];
    assign sclk_rise = sclk_cur & ~sclk_hist;
    assign ncs_fall  = ~ncs_cur & ncs_hist;
    assign ncs_rise  = ncs_cur & ~ncs_hist;

    // A frame is accepted only if it has exactly 16 bits, R/W is set to
    // write, and the address is in range.
    assign commit_ok = (bit_cnt_q == CNT_FULL) && shift_q[15] &&
                       (shift_q[14:8] <= 7'(MAX_ADDR));

    // Frame FSM state, bit counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic. In RECV, an ncs rise takes priority over an sclk rise
    // in the same cycle, so the final sclk edge is not counted.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        do_commit = 1'b0;
        do_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = ST_RECV;
                end
            end
            ST_RECV: begin
                if (ncs_rise) begin
                    state_d = ST_CHECK;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_cur};
                    // The counter stops at 17, which marks an overlong frame.
                    if (bit_cnt_q != CNT_OVF) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (commit_ok) begin
                    do_commit = 1'b1;
                end else begin
                    do_err = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Configuration registers are written on the clk edge that ends CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (do_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (shift_q[14:8] == 7'(i)) begin
                    regs_q[i] <= shift_q[7:0];
                end
            end
        end
    end

    // Register the status pulses so they line up with the register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_strobe_q <= do_commit;
            frame_err_q <= do_err;
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign wr_strobe       = wr_strobe_q;
    assign frame_err       = frame_err_q;

endmodule
